// File: rtl/riscv_mem_access_unit.sv
// Load/store unit: aligns, checks and sequences one data-memory access
// per request over a simple req/ack bus, stalling the pipeline meanwhile.
module riscv_mem_access_unit #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic [31:0] rdata,
    output logic        done,
    output logic        fault,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);

    typedef enum logic [1:0] {IDLE, REQ, DONE, ERR} state_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [1:0]  off_q, off_d;
    logic        bus_req_q, bus_req_d;
    logic        bus_we_q, bus_we_d;
    logic [31:0] bus_addr_q, bus_addr_d;
    logic [3:0]  bus_be_q, bus_be_d;
    logic [31:0] bus_wdata_q, bus_wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        done_q, done_d;
    logic        fault_q, fault_d;

    logic        req;
    logic        illegal;
    logic [3:0]  be_new;
    logic [31:0] wd_new;
    logic [31:0] shifted;
    logic [31:0] load_ext;

    assign req = MemRead | MemWrite;

    always_comb begin
        illegal = 1'b0;
        if (MemRead && MemWrite)
            illegal = 1'b1;
        if (funct3 == 3'b011 || funct3 == 3'b110 || funct3 == 3'b111)
            illegal = 1'b1;
        if (MemWrite && funct3[2])
            illegal = 1'b1;
        if (funct3[1:0] == 2'b01 && addr[0])
            illegal = 1'b1;
        if (funct3[1:0] == 2'b10 && addr[1:0] != 2'b00)
            illegal = 1'b1;
    end

    always_comb begin
        be_new = 4'b1111;
        wd_new = wdata;
        case (funct3[1:0])
            2'b00: begin
                be_new = 4'b0001 << addr[1:0];
                wd_new = {4{wdata[7:0]}};
            end
            2'b01: begin
                be_new = 4'b0011 << addr[1:0];
                wd_new = {2{wdata[15:0]}};
            end
            default: ;
        endcase
    end

    // Lane select then extend; funct3[2] picks zero-extension.
    assign shifted = bus_rdata >> {off_q, 3'b000};

    always_comb begin
        load_ext = shifted;
        case (funct3_q[1:0])
            2'b00: load_ext = funct3_q[2] ? {24'b0, shifted[7:0]}
                                          : {{24{shifted[7]}}, shifted[7:0]};
            2'b01: load_ext = funct3_q[2] ? {16'b0, shifted[15:0]}
                                          : {{16{shifted[15]}}, shifted[15:0]};
            default: ;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        funct3_d    = funct3_q;
        off_d       = off_q;
        bus_req_d   = bus_req_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_be_d    = bus_be_q;
        bus_wdata_d = bus_wdata_q;
        rdata_d     = rdata_q;
        done_d      = 1'b0;
        fault_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (req) begin
                    funct3_d = funct3;
                    off_d    = addr[1:0];
                    if (illegal) begin
                        state_d = ERR;
                        fault_d = 1'b1;
                    end else begin
                        state_d     = REQ;
                        cnt_d       = 8'd0;
                        bus_req_d   = 1'b1;
                        bus_we_d    = MemWrite;
                        bus_addr_d  = {addr[31:2], 2'b00};
                        bus_be_d    = be_new;
                        bus_wdata_d = wd_new;
                    end
                end
            end
            REQ: begin
                if (bus_ack) begin
                    state_d   = DONE;
                    bus_req_d = 1'b0;
                    done_d    = 1'b1;
                    if (!bus_we_q)
                        rdata_d = load_ext;
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = ERR;
                    bus_req_d = 1'b0;
                    fault_d   = 1'b1;
                    cnt_d     = 8'd0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            DONE:    state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= 8'd0;
            funct3_q    <= 3'b000;
            off_q       <= 2'b00;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= 32'd0;
            bus_be_q    <= 4'd0;
            bus_wdata_q <= 32'd0;
            rdata_q     <= 32'd0;
            done_q      <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            funct3_q    <= funct3_d;
            off_q       <= off_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_be_q    <= bus_be_d;
            bus_wdata_q <= bus_wdata_d;
            rdata_q     <= rdata_d;
            done_q      <= done_d;
            fault_q     <= fault_d;
        end
    end

    assign stall     = (state_q == IDLE && req) || state_q == REQ;
    assign rdata     = rdata_q;
    assign done      = done_q;
    assign fault     = fault_q;
    assign bus_req   = bus_req_q;
    assign bus_we    = bus_we_q;
    assign bus_addr  = bus_addr_q;
    assign bus_be    = bus_be_q;
    assign bus_wdata = bus_wdata_q;

endmodule

// File: tb/tb_riscv_mem_access_unit.sv
// Scoreboard bench for riscv_mem_access_unit: directed loads/stores,
// misalignment, timeout and reset-abort scenarios.
module tb_riscv_mem_access_unit;

    logic        clk;
    logic        rst;
    logic        MemRead;
    logic        MemWrite;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        stall;
    logic [31:0] rdata;
    logic        done;
    logic        fault;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    logic        resp_ack;
    logic        force_ack;
    int          ack_delay;
    int          rc;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic        flt;
        logic [31:0] rdata;
        int          nreq;
        logic [31:0] baddr;
        logic [3:0]  be;
        logic        we;
        logic [31:0] wd;
    } exp_t;

    exp_t sbq[$];

    assign bus_ack = resp_ack | force_ack;

    riscv_mem_access_unit #(.TIMEOUT(4)) dut (
        .clk(clk), .rst(rst),
        .MemRead(MemRead), .MemWrite(MemWrite),
        .funct3(funct3), .addr(addr), .wdata(wdata),
        .stall(stall), .rdata(rdata), .done(done), .fault(fault),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_be(bus_be), .bus_wdata(bus_wdata),
        .bus_ack(bus_ack), .bus_rdata(bus_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic flt, input logic [31:0] rd,
                                input int nreq, input logic [31:0] ba,
                                input logic [3:0] be, input logic we,
                                input logic [31:0] wd);
        exp_t e;
        e.flt = flt; e.rdata = rd; e.nreq = nreq;
        e.baddr = ba; e.be = be; e.we = we; e.wd = wd;
        return e;
    endfunction

    // Bus slave model: ack after ack_delay wait cycles; <0 means never.
    initial begin
        resp_ack = 1'b0;
        rc = 0;
        forever begin
            @(negedge clk);
            if (bus_req) begin
                resp_ack = (ack_delay >= 0) && (rc == ack_delay);
                rc++;
            end else begin
                resp_ack = 1'b0;
                rc = 0;
            end
        end
    end

    // Monitor: tracks the bus phase and checks each done/fault pulse.
    initial begin
        int          nreq;
        logic        unstable;
        logic [31:0] s_addr;
        logic [31:0] s_wd;
        logic [3:0]  s_be;
        logic        s_we;
        exp_t        e;
        nreq = 0;
        unstable = 1'b0;
        s_addr = '0; s_wd = '0; s_be = '0; s_we = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                nreq = 0;
                unstable = 1'b0;
            end else begin
                if (bus_req) begin
                    if (nreq == 0) begin
                        s_addr = bus_addr; s_be = bus_be;
                        s_we = bus_we; s_wd = bus_wdata;
                    end else if (bus_addr !== s_addr || bus_be !== s_be ||
                                 bus_we !== s_we || bus_wdata !== s_wd) begin
                        unstable = 1'b1;
                    end
                    nreq++;
                end
                if (done || fault) begin
                    if (sbq.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected_pulse: got done=%b fault=%b expected none",
                                 done, fault);
                    end else begin
                        e = sbq.pop_front();
                        chk("sb_fault", {31'b0, fault}, {31'b0, e.flt});
                        chk("sb_done", {31'b0, done}, {31'b0, ~e.flt});
                        chk("sb_rdata", rdata, e.rdata);
                        chk("sb_nreq", nreq, e.nreq);
                        if (e.nreq > 0) begin
                            chk("sb_bus_addr", s_addr, e.baddr);
                            chk("sb_bus_be", {28'b0, s_be}, {28'b0, e.be});
                            chk("sb_bus_we", {31'b0, s_we}, {31'b0, e.we});
                            chk("sb_bus_wdata", s_wd, e.wd);
                            chk("sb_bus_stable", {31'b0, unstable}, 32'd0);
                        end
                    end
                    nreq = 0;
                    unstable = 1'b0;
                end
            end
        end
    end

    // Issue one access and measure cycles from acceptance to done/fault.
    task automatic run(input string name, input logic rd, input logic wr,
                       input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input logic [31:0] brd,
                       input int dly, input int exp_lat, input exp_t e);
        int lat;
        sbq.push_back(e);
        @(negedge clk);
        MemRead = rd; MemWrite = wr; funct3 = f3;
        addr = a; wdata = wd; bus_rdata = brd; ack_delay = dly;
        #1;
        chk({name, "_stall_req"}, {31'b0, stall}, 32'd1);
        @(posedge clk);
        #1;
        MemRead = 1'b0; MemWrite = 1'b0;
        lat = 1;
        while (!(done || fault) && lat < 30) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk({name, "_latency"}, lat, exp_lat);
        chk({name, "_stall_end"}, {31'b0, stall}, 32'd0);
        @(posedge clk);
        #1;
        chk({name, "_pulse_gone"}, {30'b0, done, fault}, 32'd0);
        chk({name, "_req_low"}, {31'b0, bus_req}, 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        MemRead = 1'b0; MemWrite = 1'b0; funct3 = 3'b000;
        addr = '0; wdata = '0; bus_rdata = '0;
        ack_delay = 0; force_ack = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_bus_req", {31'b0, bus_req}, 32'd0);
        chk("rst_flags", {29'b0, done, fault, stall}, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_bus_addr", bus_addr, 32'd0);
        chk("rst_bus_be", {28'b0, bus_be}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        run("lb", 1, 0, 3'b000, 32'h1003, 32'h0, 32'h80AA5511, 0, 2,
            mk(0, 32'hFFFFFF80, 1, 32'h1000, 4'b1000, 0, 32'h0));
        run("sh", 0, 1, 3'b001, 32'h2002, 32'h1234BEEF, 32'h0, 3, 5,
            mk(0, 32'hFFFFFF80, 4, 32'h2000, 4'b1100, 1, 32'hBEEFBEEF));
        run("lhu_mis", 1, 0, 3'b101, 32'h3001, 32'h0, 32'h0, 0, 1,
            mk(1, 32'hFFFFFF80, 0, 32'h0, 4'b0, 0, 32'h0));
        run("lw_mis", 1, 0, 3'b010, 32'h3002, 32'h0, 32'h0, 0, 1,
            mk(1, 32'hFFFFFF80, 0, 32'h0, 4'b0, 0, 32'h0));
        run("timeout", 1, 0, 3'b010, 32'h4000, 32'h0, 32'h0, -1, 5,
            mk(1, 32'hFFFFFF80, 4, 32'h4000, 4'b1111, 0, 32'h0));
        run("rd_wr", 1, 1, 3'b010, 32'h5000, 32'h0, 32'h0, 0, 1,
            mk(1, 32'hFFFFFF80, 0, 32'h0, 4'b0, 0, 32'h0));
        run("lbu", 1, 0, 3'b100, 32'h6000, 32'h0, 32'h00000080, 0, 2,
            mk(0, 32'h00000080, 1, 32'h6000, 4'b0001, 0, 32'h0));
        run("lh", 1, 0, 3'b001, 32'h7002, 32'h0, 32'h80010000, 0, 2,
            mk(0, 32'hFFFF8001, 1, 32'h7000, 4'b1100, 0, 32'h0));
        run("sb", 0, 1, 3'b000, 32'h8001, 32'h000000A5, 32'h0, 1, 3,
            mk(0, 32'hFFFF8001, 2, 32'h8000, 4'b0010, 1, 32'hA5A5A5A5));
        run("sw", 0, 1, 3'b010, 32'h9000, 32'hDEADBEEF, 32'h0, 0, 2,
            mk(0, 32'hFFFF8001, 1, 32'h9000, 4'b1111, 1, 32'hDEADBEEF));
        run("sbu_ill", 0, 1, 3'b100, 32'h9004, 32'h0, 32'h0, 0, 1,
            mk(1, 32'hFFFF8001, 0, 32'h0, 4'b0, 0, 32'h0));
        run("f3_011", 1, 0, 3'b011, 32'h9008, 32'h0, 32'h0, 0, 1,
            mk(1, 32'hFFFF8001, 0, 32'h0, 4'b0, 0, 32'h0));

        // Reset while waiting in REQ; a late ack must not complete anything.
        @(negedge clk);
        MemRead = 1'b1; funct3 = 3'b010; addr = 32'hA000;
        bus_rdata = 32'h12345678; ack_delay = -1;
        @(posedge clk);
        #1;
        MemRead = 1'b0;
        @(posedge clk);
        #1;
        chk("mid_req_active", {31'b0, bus_req}, 32'd1);
        #1;
        rst = 1'b1;
        #1;
        chk("rst_async_req", {31'b0, bus_req}, 32'd0);
        chk("rst_async_rdata", rdata, 32'd0);
        chk("rst_async_flags", {29'b0, done, fault, stall}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        force_ack = 1'b1;
        @(negedge clk);
        force_ack = 1'b0;
        repeat (4) @(negedge clk);
        chk("post_rst_rdata", rdata, 32'd0);
        chk("post_rst_req", {31'b0, bus_req}, 32'd0);

        repeat (3) @(negedge clk);
        chk("sb_empty", sbq.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
